mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- E-stage multiply/divide unit: the producer side of the EM pipeline register's MDU result field (E_MDUAns).
- Holds the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- Serves MFHI/MFLO reads combinationally and MTHI/MTLO writes in one cycle.
- Exports busy so the hazard unit can stall later MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  E-stage instruction is an MDU op; sampled on the rising edge.
- op  in  4  MDU operation code (package constants).
- A  in  32  rs operand, after forwarding.
- B  in  32  rt operand, after forwarding.
- busy  out  1  registered; high while a mult/div is in flight.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- MDUAns  out  32  combinational: HI for MDU_MFHI, LO for MDU_MFLO, 0 otherwise.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): HI=0, LO=0, busy=0, state=IDLE, counter=0, pending result discarded. MDUAns then follows HI/LO=0.
- States:
  - IDLE -> MUL on start&&op∈{MULT,MULTU}; counter loaded with MULT_CYCLES.
  - IDLE -> DIV on start&&op∈{DIV,DIVU}; counter loaded with DIV_CYCLES.
  - MUL/DIV: counter decrements each cycle; at counter==1, that edge commits the pending HI/LO and returns to IDLE.
- Latency: start sampled at edge t0; busy=1 for exactly N cycles after t0 (N = MULT_CYCLES or DIV_CYCLES); HI/LO change at edge t0+N; busy=0 from that same edge.
- Operands are captured at t0. Pending result is computed from the captured values; later changes on A/B have no effect.
- MULT: {HI,LO} = signed(A)*signed(B), 64-bit. MULTU: unsigned 64-bit product.
- DIV (signed): LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, remainder in HI.
- Divide by zero (DIV or DIVU): full N-cycle busy; HI/LO retain their old values at commit.
- MTHI/MTLO: start in IDLE writes A into HI/LO at the next edge; busy stays 0.
- MFHI/MFLO: no state change; MDUAns reflects the current HI/LO.
- While busy, HI/LO and MDUAns show the old (pre-operation) values.
- start while busy: ignored entirely, with no state, HI/LO, or counter change. The hazard unit guarantees this never occurs; the block must still be robust to it.
- start with a non-MDU or unknown op: ignored.
- The unit has no flush input. An issued mult/div always completes, because E-stage instructions are never flushed in this design.

Decomposition:
- def.v constants:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MFHI=5, MDU_MFLO=6, MDU_MTHI=7, MDU_MTLO=8.
  - State encodings MDU_IDLE, MDU_MUL, MDU_DIV.
- Optional sub-module mdu_arith: purely combinational. From op, A, B it produces the 64-bit pending {hi,lo} and a div0 flag; it is registered at start.
- Control FSM, counter and HI/LO registers stay in mul_div_unit.

Test Plan:
- Assert reset mid-DIV (cycle 4 of 10) -> busy=0, HI=LO=0 immediately, without waiting for a clock edge. No later commit occurs.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 -> LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV A=5, B=0 after MTHI 0x11/MTLO 0x22 -> busy 10 cycles; then HI=0x11, LO=0x22 (unchanged).
- Pulse start with MULT (A=2, B=3) during cycle 2 of an in-flight DIVU 9/4 -> ignored. Final HI=1, LO=2, and busy drops after 10 cycles total.
- MTLO A=0x1234, then op=MFLO the next cycle -> MDUAns=0x1234, busy stays 0. During a MULT, op=MFHI -> MDUAns = old HI until commit.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the E-stage multiply/divide unit: MDU op codes,
// controller state encoding and op-class helpers.
package mul_div_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  // State names carry an _S_ infix so they cannot collide with the op constants.
  typedef enum logic [1:0] {
    MDU_S_IDLE = 2'd0,
    MDU_S_MUL  = 2'd1,
    MDU_S_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_arith.sv
// Combinational datapath: 64-bit {hi,lo} result and divide-by-zero flag
// for MULT/MULTU/DIV/DIVU. The result is captured by the controller at start.
module mul_div_unit_arith
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic        signed_div_s;
  logic [31:0] num_s;
  logic [31:0] den_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Sign-magnitude divide: one unsigned divider serves both DIV and DIVU,
  // which also makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
  always_comb begin
    signed_div_s = (op == MDU_DIV);
    num_s   = (signed_div_s && a[31]) ? (32'd0 - a) : a;
    den_s   = (signed_div_s && b[31]) ? (32'd0 - b) : b;
    den_s   = (den_s == 32'd0) ? 32'd1 : den_s;
    q_mag_s = num_s / den_s;
    r_mag_s = num_s % den_s;
    q_s     = (signed_div_s && (a[31] ^ b[31])) ? (32'd0 - q_mag_s) : q_mag_s;
    r_s     = (signed_div_s && a[31]) ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Result selection per op; non-arithmetic ops yield zero.
  always_comb begin
    result = 64'd0;
    div0   = 1'b0;
    case (op)
      MDU_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MDU_MULTU: result = {32'd0, a} * {32'd0, b};
      MDU_DIV, MDU_DIVU: begin
        result = {r_s, q_s};
        div0   = (b == 32'd0);
      end
      default: begin
        result = 64'd0;
        div0   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency mult/div
// controller, MTHI/MTLO writes and the combinational MFHI/MFLO answer.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUAns
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             busy_r, busy_s;
  logic [31:0]      hi_r, hi_s;
  logic [31:0]      lo_r, lo_s;
  logic [63:0]      pend_r, pend_s;
  logic             div0_r, div0_s;
  logic [63:0]      arith_result_s;
  logic             arith_div0_s;

  mul_div_unit_arith u_arith (
    .op     (op),
    .a      (A),
    .b      (B),
    .result (arith_result_s),
    .div0   (arith_div0_s)
  );

  // Next-state logic: issue from IDLE, count down while busy, commit at count 1.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    busy_s  = busy_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    pend_s  = pend_r;
    div0_s  = div0_r;
    case (state_r)
      MDU_S_IDLE: begin
        if (start && is_mul_op(op)) begin
          state_s = MDU_S_MUL;
          count_s = MULT_LOAD;
          busy_s  = 1'b1;
          pend_s  = arith_result_s;
          div0_s  = 1'b0;
        end else if (start && is_div_op(op)) begin
          state_s = MDU_S_DIV;
          count_s = DIV_LOAD;
          busy_s  = 1'b1;
          pend_s  = arith_result_s;
          div0_s  = arith_div0_s;
        end else if (start && (op == MDU_MTHI)) begin
          hi_s = A;
        end else if (start && (op == MDU_MTLO)) begin
          lo_s = A;
        end else begin
          state_s = MDU_S_IDLE;
        end
      end
      MDU_S_MUL, MDU_S_DIV: begin
        // Any start arriving here is deliberately ignored.
        if (count_r == CNT_ONE) begin
          state_s = MDU_S_IDLE;
          count_s = CNT_ZERO;
          busy_s  = 1'b0;
          if (!div0_r) begin
            hi_s = pend_r[63:32];
            lo_s = pend_r[31:0];
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          count_s = count_r - CNT_ONE;
        end
      end
      default: begin
        state_s = MDU_S_IDLE;
        count_s = CNT_ZERO;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= MDU_S_IDLE;
      count_r <= CNT_ZERO;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      pend_r  <= 64'd0;
      div0_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      busy_r  <= busy_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      pend_r  <= pend_s;
      div0_r  <= div0_s;
    end
  end

  // MFHI/MFLO answer for the EM pipeline register.
  always_comb begin
    MDUAns = 32'd0;
    case (op)
      MDU_MFHI: MDUAns = hi_r;
      MDU_MFLO: MDUAns = lo_r;
      default:  MDUAns = 32'd0;
    endcase
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule
